// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit: jump opcodes,
// pipeline flush masks and 2-bit predictor counter states.
package branch_predict_unit_pkg;

    localparam int JUMP_BITS = 4;

    localparam logic [JUMP_BITS-1:0] JMP_OP_NOP = 4'd0;
    localparam logic [JUMP_BITS-1:0] JMP_OP_J   = 4'd1;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JR  = 4'd2;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JEQ = 4'd3;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JNE = 4'd4;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JZ  = 4'd5;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JNZ = 4'd6;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JL  = 4'd7;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JLE = 4'd8;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JG  = 4'd9;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JGE = 4'd10;

    // One bit per pipeline register that can be flushed.
    localparam int NUM_PIPE_MASKS = 4;

    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC     = 4'b0001;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID  = 4'b0010;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX  = 4'b0100;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_EX_MEM = 4'b1000;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_FLUSH_ALL  =
        PIPE_REG_EX_MEM | PIPE_REG_ID_EX | PIPE_REG_IF_ID | PIPE_REG_PC;

    // 2-bit saturating predictor states; bit 1 is the taken prediction.
    localparam logic [1:0] BP_CTR_SNT = 2'd0;
    localparam logic [1:0] BP_CTR_WNT = 2'd1;
    localparam logic [1:0] BP_CTR_WT  = 2'd2;
    localparam logic [1:0] BP_CTR_ST  = 2'd3;

    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == BP_CTR_ST) ? BP_CTR_ST : ctr + 2'd1;
        end
        return (ctr == BP_CTR_SNT) ? BP_CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb.sv
// Direct-mapped branch target buffer storage. Two asynchronous read ports
// (fetch lookup and EX-stage update lookup), one synchronous write port,
// and a synchronous invalidate-all that takes priority over the write.
module bp_btb
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ENTRIES    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear_i,
    input  logic [$clog2(ENTRIES)-1:0]            rd_idx_i,
    output logic                                  rd_valid_o,
    output logic [ADDR_WIDTH-$clog2(ENTRIES)-1:0] rd_tag_o,
    output logic [ADDR_WIDTH-1:0]                 rd_target_o,
    output logic [1:0]                            rd_ctr_o,
    input  logic [$clog2(ENTRIES)-1:0]            up_idx_i,
    output logic                                  up_valid_o,
    output logic [ADDR_WIDTH-$clog2(ENTRIES)-1:0] up_tag_o,
    output logic [ADDR_WIDTH-1:0]                 up_target_o,
    output logic [1:0]                            up_ctr_o,
    input  logic                                  wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0]            wr_idx_i,
    input  logic [ADDR_WIDTH-$clog2(ENTRIES)-1:0] wr_tag_i,
    input  logic [ADDR_WIDTH-1:0]                 wr_target_i,
    input  logic [1:0]                            wr_ctr_i
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign up_valid_o  = valid_q[up_idx_i];
    assign up_tag_o    = tag_q[up_idx_i];
    assign up_target_o = target_q[up_idx_i];
    assign up_ctr_o    = ctr_q[up_idx_i];

    // Storage update: reset to weak-not-taken, clear wins over a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_CTR_WNT;
            end
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i]  <= 1'b1;
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            ctr_q[wr_idx_i]    <= wr_ctr_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit: fetch-stage BTB prediction,
// EX-stage resolution (flush mask, redirect address), BTB update policy
// and wrap-around performance counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     pc,
    output logic                      take_branch,
    output logic [ADDR_WIDTH-1:0]     branch_predict,
    input  logic [JUMP_BITS-1:0]      jop,
    input  logic                      zero,
    input  logic                      less,
    input  logic                      greater,
    input  logic [ADDR_WIDTH-1:0]     id_ex_pc,
    input  logic [ADDR_WIDTH-1:0]     id_ex_reg_address,
    input  logic [ADDR_WIDTH-1:0]     id_ex_imm_address,
    input  logic                      branch_taken,
    input  logic [ADDR_WIDTH-1:0]     branch_taken_address,
    input  logic                      ex_stall,
    input  logic                      btb_clear,
    output logic [NUM_PIPE_MASKS-1:0] flush,
    output logic [ADDR_WIDTH-1:0]     jump_address,
    output logic [CNT_WIDTH-1:0]      branch_count,
    output logic [CNT_WIDTH-1:0]      mispredict_count
);

    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;

    logic                  rd_valid, up_valid;
    logic [TAG_BITS-1:0]   rd_tag, up_tag;
    logic [ADDR_WIDTH-1:0] rd_target, up_target;
    logic [1:0]            rd_ctr, up_ctr;

    logic                  wr_en;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [ADDR_WIDTH-1:0] wr_target;
    logic [1:0]            wr_ctr;

    logic                  is_cond, is_jr, is_j, is_branch, branch_cond;
    logic                  actual_taken, mispredict, upd_en, up_hit;
    logic [ADDR_WIDTH-1:0] actual_target;

    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

    bp_btb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ENTRIES    (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst_n       (reset),
        .clear_i     (btb_clear),
        .rd_idx_i    (pc[IDX_BITS-1:0]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_ctr_o    (rd_ctr),
        .up_idx_i    (id_ex_pc[IDX_BITS-1:0]),
        .up_valid_o  (up_valid),
        .up_tag_o    (up_tag),
        .up_target_o (up_target),
        .up_ctr_o    (up_ctr),
        .wr_en_i     (wr_en),
        .wr_idx_i    (id_ex_pc[IDX_BITS-1:0]),
        .wr_tag_i    (wr_tag),
        .wr_target_i (wr_target),
        .wr_ctr_i    (wr_ctr)
    );

    // Fetch prediction; the storage resets to zero so outputs are 0 in reset.
    assign take_branch    = rd_valid && (rd_tag == pc[ADDR_WIDTH-1:IDX_BITS]) && (rd_ctr >= BP_CTR_WT);
    assign branch_predict = rd_target;

    // Opcode decode into branch class and condition outcome.
    always_comb begin
        is_cond     = 1'b0;
        is_jr       = 1'b0;
        is_j        = 1'b0;
        branch_cond = 1'b0;
        case (jop)
            JMP_OP_JEQ, JMP_OP_JZ:  begin is_cond = 1'b1; branch_cond = zero;           end
            JMP_OP_JNE, JMP_OP_JNZ: begin is_cond = 1'b1; branch_cond = !zero;          end
            JMP_OP_JL:              begin is_cond = 1'b1; branch_cond = less;           end
            JMP_OP_JLE:             begin is_cond = 1'b1; branch_cond = less | zero;    end
            JMP_OP_JG:              begin is_cond = 1'b1; branch_cond = greater;        end
            JMP_OP_JGE:             begin is_cond = 1'b1; branch_cond = greater | zero; end
            JMP_OP_JR:              is_jr = 1'b1;
            JMP_OP_J:               is_j  = 1'b1;
            default:                ;
        endcase
    end

    assign is_branch     = is_cond | is_jr;
    assign actual_taken  = is_jr | (is_cond & branch_cond);
    assign actual_target = is_jr ? id_ex_reg_address : id_ex_imm_address;
    assign mispredict    = is_branch &&
                           ((branch_taken != actual_taken) ||
                            (branch_taken && actual_taken && (branch_taken_address != actual_target)));

    // Flush mask and redirect; a wrongly-predicted-taken branch resumes at the fall-through PC.
    always_comb begin
        flush        = '0;
        jump_address = actual_target;
        if (is_branch) begin
            if (mispredict) begin
                flush = PIPE_FLUSH_ALL;
            end else if (actual_taken) begin
                flush = PIPE_REG_EX_MEM;
            end
            if (branch_taken && !actual_taken) begin
                jump_address = id_ex_pc + ADDR_WIDTH'(1);
            end
        end else if (is_j) begin
            flush = PIPE_REG_EX_MEM;
        end
    end

    assign upd_en = is_branch && !ex_stall;
    assign up_hit = up_valid && (up_tag == id_ex_pc[ADDR_WIDTH-1:IDX_BITS]);

    // BTB update policy: train on hit, allocate weak-taken on a taken miss.
    always_comb begin
        wr_en     = 1'b0;
        wr_tag    = id_ex_pc[ADDR_WIDTH-1:IDX_BITS];
        wr_target = up_target;
        wr_ctr    = up_ctr;
        if (upd_en) begin
            if (up_hit) begin
                wr_en  = 1'b1;
                wr_ctr = bp_ctr_next(up_ctr, actual_taken);
                if (actual_taken) begin
                    wr_target = actual_target;
                end
            end else if (actual_taken) begin
                wr_en     = 1'b1;
                wr_target = actual_target;
                wr_ctr    = BP_CTR_WT;
            end
        end
    end

    // Performance counter next state; both wrap naturally at 2^CNT_WIDTH.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_en) begin
            branch_count_d = branch_count_q + CNT_WIDTH'(1);
            if (mispredict) begin
                mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed sequences, a
// resolution vector table and randomized traffic against a reference model.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int AW  = 16;
    localparam int ENT = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [AW-1:0] pc = '0, id_ex_pc = '0, id_ex_reg_address = '0, id_ex_imm_address = '0;
    logic [AW-1:0] branch_taken_address = '0;
    logic [JUMP_BITS-1:0] jop = JMP_OP_NOP;
    logic zero = 0, less = 0, greater = 0, branch_taken = 0, ex_stall = 0, btb_clear = 0;

    logic                      take_branch, take_branch4;
    logic [AW-1:0]             branch_predict, branch_predict4, jump_address, jump_address4;
    logic [NUM_PIPE_MASKS-1:0] flush, flush4;
    logic [31:0]               branch_count, mispredict_count;
    logic [3:0]                branch_count4, mispredict_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.ADDR_WIDTH(AW), .BTB_ENTRIES(ENT), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .take_branch(take_branch), .branch_predict(branch_predict),
        .jop(jop), .zero(zero), .less(less), .greater(greater), .id_ex_pc(id_ex_pc),
        .id_ex_reg_address(id_ex_reg_address), .id_ex_imm_address(id_ex_imm_address),
        .branch_taken(branch_taken), .branch_taken_address(branch_taken_address),
        .ex_stall(ex_stall), .btb_clear(btb_clear), .flush(flush), .jump_address(jump_address),
        .branch_count(branch_count), .mispredict_count(mispredict_count));

    branch_predict_unit #(.ADDR_WIDTH(AW), .BTB_ENTRIES(ENT), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .pc(pc), .take_branch(take_branch4), .branch_predict(branch_predict4),
        .jop(jop), .zero(zero), .less(less), .greater(greater), .id_ex_pc(id_ex_pc),
        .id_ex_reg_address(id_ex_reg_address), .id_ex_imm_address(id_ex_imm_address),
        .branch_taken(branch_taken), .branch_taken_address(branch_taken_address),
        .ex_stall(ex_stall), .btb_clear(btb_clear), .flush(flush4), .jump_address(jump_address4),
        .branch_count(branch_count4), .mispredict_count(mispredict_count4));

    // ---------------- reference model ----------------
    bit          m_valid [ENT];
    int          m_tag   [ENT];
    int          m_tgt   [ENT];
    int          m_ctr   [ENT];
    int unsigned m_bc, m_mc;

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endtask

    function automatic bit m_is_branch();
        return jop == JMP_OP_JR || (jop >= JMP_OP_JEQ && jop <= JMP_OP_JGE);
    endfunction

    function automatic bit m_taken();
        if (jop == JMP_OP_JR) return 1;
        if (jop == JMP_OP_JEQ || jop == JMP_OP_JZ) return zero;
        if (jop == JMP_OP_JNE || jop == JMP_OP_JNZ) return !zero;
        if (jop == JMP_OP_JL)  return less;
        if (jop == JMP_OP_JLE) return less || zero;
        if (jop == JMP_OP_JG)  return greater;
        if (jop == JMP_OP_JGE) return greater || zero;
        return 0;
    endfunction

    function automatic int m_target();
        return (jop == JMP_OP_JR) ? int'(id_ex_reg_address) : int'(id_ex_imm_address);
    endfunction

    function automatic bit m_mispredict();
        if (!m_is_branch()) return 0;
        if (branch_taken != m_taken()) return 1;
        return branch_taken && m_taken() && (int'(branch_taken_address) != m_target());
    endfunction

    function automatic logic [3:0] m_flush();
        if (m_is_branch()) return m_mispredict() ? 4'hF : (m_taken() ? 4'h8 : 4'h0);
        if (jop == JMP_OP_J) return 4'h8;
        return 4'h0;
    endfunction

    function automatic logic [AW-1:0] m_jump();
        if (m_is_branch() && branch_taken && !m_taken()) return AW'((int'(id_ex_pc) + 1) % 65536);
        return AW'(m_target());
    endfunction

    function automatic bit m_pred_take(input int a);
        return m_valid[a % ENT] && m_tag[a % ENT] == a / ENT && m_ctr[a % ENT] >= 2;
    endfunction

    task automatic m_update();
        int idx, t;
        idx = int'(id_ex_pc) % ENT;
        t   = int'(id_ex_pc) / ENT;
        if (m_is_branch() && !ex_stall) begin
            if (m_valid[idx] && m_tag[idx] == t) begin
                m_ctr[idx] = m_taken() ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                       : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                if (m_taken()) m_tgt[idx] = m_target();
            end else if (m_taken()) begin
                m_valid[idx] = 1; m_tag[idx] = t; m_tgt[idx] = m_target(); m_ctr[idx] = 2;
            end
            m_bc++;
            if (m_mispredict()) m_mc++;
        end
        if (btb_clear) begin
            for (int i = 0; i < ENT; i++) m_valid[i] = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [AW-1:0] idpc, input logic z, input logic l,
                         input logic g, input logic bt, input logic [AW-1:0] bta,
                         input logic [AW-1:0] imm, input logic [AW-1:0] rg,
                         input logic stall = 0, input logic clr = 0);
        jop = op; id_ex_pc = idpc; zero = z; less = l; greater = g; branch_taken = bt;
        branch_taken_address = bta; id_ex_imm_address = imm; id_ex_reg_address = rg;
        ex_stall = stall; btb_clear = clr;
    endtask

    task automatic nop();
        drive(JMP_OP_NOP, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    // Combinational outputs are compared mid-cycle against the model.
    task automatic settle();
        #4;
        check("flush", flush, m_flush());
        check("jump_address", jump_address, m_jump());
        check("take_branch", take_branch, m_pred_take(int'(pc)));
        if (m_pred_take(int'(pc))) check("branch_predict", branch_predict, m_tgt[int'(pc) % ENT]);
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
        check("branch_count", branch_count, m_bc);
        check("mispredict_count", mispredict_count, m_mc);
        check("branch_count_w4", branch_count4, m_bc % 16);
        check("mispredict_count_w4", mispredict_count4, m_mc % 16);
    endtask

    typedef struct {
        logic [3:0]    op;
        logic          z, l, g, bt;
        logic [AW-1:0] bta, idpc, imm, rg;
        logic [3:0]    ef;
        logic [AW-1:0] ej;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic z, input logic l, input logic g,
                                input logic bt, input logic [AW-1:0] bta, input logic [AW-1:0] idpc,
                                input logic [3:0] ef, input logic [AW-1:0] ej);
        vec_t v;
        v.op = op; v.z = z; v.l = l; v.g = g; v.bt = bt; v.bta = bta; v.idpc = idpc;
        v.imm = 16'h0099; v.rg = 16'h01A0; v.ef = ef; v.ej = ej;
        return v;
    endfunction

    vec_t vecs [13];
    int unsigned saved_bc, saved_mc;

    initial begin
        vecs[0]  = mk(JMP_OP_JEQ, 1, 0, 0, 0, 16'h0000, 16'h0012, 4'hF, 16'h0099);
        vecs[1]  = mk(JMP_OP_JNE, 1, 0, 0, 0, 16'h0000, 16'h0012, 4'h0, 16'h0099);
        vecs[2]  = mk(JMP_OP_JL,  0, 1, 0, 1, 16'h0099, 16'h0012, 4'h8, 16'h0099);
        vecs[3]  = mk(JMP_OP_JLE, 1, 0, 0, 1, 16'h0099, 16'h0012, 4'h8, 16'h0099);
        vecs[4]  = mk(JMP_OP_JG,  0, 0, 0, 1, 16'h0099, 16'hFFFF, 4'hF, 16'h0000);
        vecs[5]  = mk(JMP_OP_JGE, 0, 0, 0, 0, 16'h0000, 16'h0012, 4'h0, 16'h0099);
        vecs[6]  = mk(JMP_OP_JZ,  0, 0, 0, 1, 16'h0050, 16'h0012, 4'hF, 16'h0013);
        vecs[7]  = mk(JMP_OP_JNZ, 0, 0, 0, 1, 16'h0050, 16'h0012, 4'hF, 16'h0099);
        vecs[8]  = mk(JMP_OP_JR,  0, 0, 0, 1, 16'h0099, 16'h0012, 4'hF, 16'h01A0);
        vecs[9]  = mk(JMP_OP_JR,  0, 0, 0, 1, 16'h01A0, 16'h0012, 4'h8, 16'h01A0);
        vecs[10] = mk(JMP_OP_J,   0, 0, 0, 0, 16'h0000, 16'h0012, 4'h8, 16'h0099);
        vecs[11] = mk(JMP_OP_NOP, 0, 0, 0, 0, 16'h0000, 16'h0012, 4'h0, 16'h0099);
        vecs[12] = mk(JMP_OP_JGE, 0, 0, 1, 0, 16'h0000, 16'h0012, 4'hF, 16'h0099);

        // Reset state
        m_reset();
        pc = 16'h0040;
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_take_branch", take_branch, 0);
        check("rst_branch_predict", branch_predict, 16'h0);
        check("rst_branch_count", branch_count, 0);
        check("rst_mispredict_count", mispredict_count, 0);
        reset = 1'b1;
        settle();
        check("post_rst_take_branch", take_branch, 0);
        tick();

        // Cold miss, taken: full flush, then learned prediction
        drive(JMP_OP_JEQ, 16'h0010, 1, 0, 0, 0, 16'h0, 16'h0080, 16'h0);
        settle();
        check("jeq_cold_flush", flush, 4'hF);
        check("jeq_cold_jump", jump_address, 16'h0080);
        tick();
        pc = 16'h0010; nop();
        settle();
        check("learned_take", take_branch, 1);
        check("learned_target", branch_predict, 16'h0080);
        check("mispredict_after_cold", mispredict_count, 1);
        tick();

        // Counter training 2 -> 1 -> 0 -> 1
        drive(JMP_OP_JEQ, 16'h0010, 0, 0, 0, 1, 16'h0080, 16'h0080, 16'h0);
        settle();
        check("nt1_jump", jump_address, 16'h0011);
        tick();
        settle();
        check("nt2_take_branch", take_branch, 0);
        check("nt2_flush", flush, 4'hF);
        check("nt2_jump", jump_address, 16'h0011);
        tick();
        drive(JMP_OP_JEQ, 16'h0010, 1, 0, 0, 0, 16'h0, 16'h0080, 16'h0);
        settle();
        tick();
        nop();
        settle();
        check("after_train_take", take_branch, 0);
        tick();

        // JR with a wrong predicted target, then a correct repeat
        drive(JMP_OP_JR, 16'h0020, 0, 0, 0, 1, 16'h00F0, 16'h0000, 16'h0100);
        settle();
        check("jr_flush", flush, 4'hF);
        check("jr_jump", jump_address, 16'h0100);
        tick();
        pc = 16'h0020;
        drive(JMP_OP_JR, 16'h0020, 0, 0, 0, 1, 16'h0100, 16'h0000, 16'h0100);
        settle();
        check("jr_btb_target", branch_predict, 16'h0100);
        check("jr_repeat_flush", flush, 4'h8);
        tick();

        // Aliasing eviction, and same-index read during a write sees old contents
        pc = 16'h0002;
        drive(JMP_OP_JEQ, 16'h0002, 1, 0, 0, 0, 16'h0, 16'h0055, 16'h0);
        settle(); tick();
        drive(JMP_OP_JEQ, 16'h0012, 1, 0, 0, 0, 16'h0, 16'h0066, 16'h0);
        settle();
        check("no_bypass_take", take_branch, 1);
        check("no_bypass_target", branch_predict, 16'h0055);
        tick();
        nop();
        settle();
        check("evicted_take", take_branch, 0);
        tick();
        pc = 16'h0012;
        settle();
        check("alias_new_take", take_branch, 1);
        tick();

        // Resolution table under ex_stall: outputs driven, no state changes
        saved_bc = m_bc; saved_mc = m_mc;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].idpc, vecs[i].z, vecs[i].l, vecs[i].g, vecs[i].bt,
                  vecs[i].bta, vecs[i].imm, vecs[i].rg, 1'b1, 1'b0);
            settle();
            check($sformatf("vec%0d_flush", i), flush, vecs[i].ef);
            check($sformatf("vec%0d_jump", i), jump_address, vecs[i].ej);
            tick();
        end
        check("stall_branch_count", branch_count, saved_bc);
        check("stall_mispredict_count", mispredict_count, saved_mc);
        nop();
        settle();
        check("stall_btb_kept", take_branch, 1);
        check("stall_btb_target", branch_predict, 16'h0066);
        tick();

        // btb_clear coinciding with a taken update
        pc = 16'h0030;
        drive(JMP_OP_JEQ, 16'h0030, 1, 0, 0, 0, 16'h0, 16'h0077, 16'h0, 1'b0, 1'b1);
        settle(); tick();
        check("clear_counts_branch", branch_count, saved_bc + 1);
        nop();
        settle();
        check("clear_beats_update", take_branch, 0);
        tick();
        pc = 16'h0012;
        settle();
        check("clear_all", take_branch, 0);
        tick();

        // Mid-operation reset discards learned state
        pc = 16'h0005;
        drive(JMP_OP_JEQ, 16'h0005, 1, 0, 0, 0, 16'h0, 16'h0123, 16'h0);
        settle(); tick();
        nop();
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        check("midrst_take", take_branch, 0);
        check("midrst_predict", branch_predict, 16'h0);
        check("midrst_count", branch_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(JMP_OP_JEQ, 16'h0005, 1, 0, 0, 0, 16'h0, 16'h0123, 16'h0);
        settle();
        check("cold_after_rst_take", take_branch, 0);
        check("cold_after_rst_flush", flush, 4'hF);
        tick();

        // 4-bit counter wraps after 16 branches (1 already counted)
        for (int i = 0; i < 15; i++) begin
            drive(JMP_OP_JNE, 16'h0008, 1, 0, 0, 0, 16'h0, 16'h0200, 16'h0);
            settle(); tick();
        end
        check("wrap_count4", branch_count4, 4'd0);
        check("wrap_count32", branch_count, 16);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [3:0]    op;
            logic [AW-1:0] a, bta;
            logic          bt;
            a  = AW'($urandom_range(0, 47));
            op = ($urandom_range(0, 7) == 0) ? JMP_OP_NOP : 4'($urandom_range(1, 10));
            if ($urandom_range(0, 9) < 7) begin
                bt  = m_pred_take(int'(a));
                bta = AW'(m_tgt[int'(a) % ENT]);
            end else begin
                bt  = 1'($urandom_range(0, 1));
                bta = AW'(16'h0100 + $urandom_range(0, 3));
            end
            if (!(op == JMP_OP_JR || (op >= JMP_OP_JEQ && op <= JMP_OP_JGE))) bt = 0;
            pc = AW'($urandom_range(0, 47));
            drive(op, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  bt, bta, AW'(16'h0100 + $urandom_range(0, 3)), AW'(16'h0100 + $urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
